ad9363_rx_deframer: RTL and testbench

- Parametrised receive deframer for the AD9363 CMOS DDR port. It sits after the IDDR capture stage, in the rx_data_clk domain.
- Accepts the rising- and falling-edge data and frame samples and detects/corrects a half-cycle frame slip.
- Supports 1R1T and 2R2T channel modes, selectable at runtime.
- Maintains frame lock with a status flag and a saturating frame-error counter, and delivers aligned I/Q words for up to two channels to user logic.

---
 rtl/ad9363_pkg.sv | 26 ++
 rtl/ad9363_rx_phase_align.sv | 39 +++
 rtl/ad9363_rx_deframer.sv | 190 +++++++++++++++++++
 tb/tb_ad9363_rx_deframer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9363_pkg.sv
// Shared state encodings, mode constants and frame patterns for the AD9363 RX deframer.
package ad9363_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

    localparam logic MODE_1R1T = 1'b0;
    localparam logic MODE_2R2T = 1'b1;

    localparam logic [1:0] FRM_1R    = 2'b10;
    localparam logic [1:0] FRM_2R_S0 = 2'b11;
    localparam logic [1:0] FRM_2R_S1 = 2'b00;
    // Raw (rise, fall) frame pattern seen when the frame is captured half a cycle late.
    localparam logic [1:0] FRM_SLIP  = 2'b01;

    function automatic logic [1:0] expected_frame(input logic mode, input logic slot);
        if (mode == MODE_1R1T) begin
            return FRM_1R;
        end
        return slot ? FRM_2R_S1 : FRM_2R_S0;
    endfunction

endpackage

// File: rtl/ad9363_rx_phase_align.sv
// Rebuilds the (a, b) sample pair from the IDDR outputs, optionally shifted by half a cycle.
module ad9363_rx_phase_align
    import ad9363_pkg::*;
#(
    parameter int DATA_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              phase_i,
    input  logic [DATA_W-1:0] data_p_i,
    input  logic [DATA_W-1:0] data_n_i,
    input  logic              frame_p_i,
    input  logic              frame_n_i,
    output logic [DATA_W-1:0] a_data_o,
    output logic              a_frame_o,
    output logic [DATA_W-1:0] b_data_o,
    output logic              b_frame_o
);

    logic [DATA_W-1:0] prev_n_q;
    logic              prev_fn_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prev_n_q  <= '0;
            prev_fn_q <= 1'b0;
        end else begin
            prev_n_q  <= data_n_i;
            prev_fn_q <= frame_n_i;
        end
    end

    // In slipped phase the first half of a word arrived on the previous falling edge.
    assign a_data_o  = phase_i ? prev_n_q  : data_p_i;
    assign a_frame_o = phase_i ? prev_fn_q : frame_p_i;
    assign b_data_o  = phase_i ? data_p_i  : data_n_i;
    assign b_frame_o = phase_i ? frame_p_i : frame_n_i;

endmodule

// File: rtl/ad9363_rx_deframer.sv
// AD9363 CMOS DDR receive deframer: frame search, lock tracking and I/Q word assembly.
module ad9363_rx_deframer
    import ad9363_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic              rx_data_clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ddr_data_p,
    input  logic [DATA_W-1:0] ddr_data_n,
    input  logic              ddr_frame_p,
    input  logic              ddr_frame_n,
    input  logic              mode_2r2t,
    input  logic              err_clr,
    output logic              adc_valid,
    output logic [DATA_W-1:0] adc_data_i0,
    output logic [DATA_W-1:0] adc_data_q0,
    output logic [DATA_W-1:0] adc_data_i1,
    output logic [DATA_W-1:0] adc_data_q1,
    output logic              rx_status,
    output logic              align_phase,
    output logic [ERR_W-1:0]  frame_err_cnt
);

    localparam logic [7:0] LOCK_TGT = 8'(LOCK_CNT);

    rx_state_e         state_q, state_d;
    logic              phase_q, phase_d;
    logic              slot_q, slot_d;
    logic [7:0]        good_q, good_d;
    logic [DATA_W-1:0] hold_i_q, hold_i_d, hold_q_q, hold_q_d;
    logic              mode_q;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] i0_q, i0_d, q0_q, q0_d, i1_q, i1_d, q1_q, q1_d;

    logic [DATA_W-1:0] a_data, b_data;
    logic              a_frame, b_frame;
    logic [1:0]        raw_frm;
    logic              frm_ok, mode_chg, lost;

    ad9363_rx_phase_align #(.DATA_W(DATA_W)) u_align (
        .clk_i     (rx_data_clk),
        .rst_ni    (rst_n),
        .phase_i   (phase_q),
        .data_p_i  (ddr_data_p),
        .data_n_i  (ddr_data_n),
        .frame_p_i (ddr_frame_p),
        .frame_n_i (ddr_frame_n),
        .a_data_o  (a_data),
        .a_frame_o (a_frame),
        .b_data_o  (b_data),
        .b_frame_o (b_frame)
    );

    assign raw_frm  = {ddr_frame_p, ddr_frame_n};
    assign frm_ok   = ({a_frame, b_frame} == expected_frame(mode_2r2t, slot_q));
    assign mode_chg = (mode_2r2t != mode_q);

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        slot_d   = slot_q;
        good_d   = good_q;
        hold_i_d = hold_i_q;
        hold_q_d = hold_q_q;
        valid_d  = 1'b0;
        i0_d     = '0;
        q0_d     = '0;
        i1_d     = '0;
        q1_d     = '0;
        lost     = 1'b0;

        if (state_q != SEARCH) begin
            slot_d = ~slot_q;
            if (!slot_q) begin
                hold_i_d = a_data;
                hold_q_d = b_data;
            end
        end

        case (state_q)
            SEARCH: begin
                if (mode_2r2t == MODE_2R2T) begin
                    if (raw_frm == FRM_2R_S0 || raw_frm == FRM_SLIP) begin
                        state_d = VERIFY;
                        phase_d = (raw_frm == FRM_SLIP);
                        slot_d  = 1'b1;
                        good_d  = '0;
                    end
                end else if (raw_frm == FRM_1R || raw_frm == FRM_SLIP) begin
                    state_d = VERIFY;
                    phase_d = (raw_frm == FRM_SLIP);
                    good_d  = '0;
                end
            end
            VERIFY: begin
                if (frm_ok) begin
                    good_d = good_q + 8'd1;
                    if (good_q + 8'd1 == LOCK_TGT) begin
                        state_d = LOCKED;
                    end
                end else begin
                    state_d = SEARCH;
                end
            end
            LOCKED: begin
                if (!frm_ok) begin
                    state_d = SEARCH;
                    lost    = 1'b1;
                end else if (mode_2r2t == MODE_1R1T) begin
                    valid_d = 1'b1;
                    i0_d    = a_data;
                    q0_d    = b_data;
                end else if (slot_q) begin
                    valid_d = 1'b1;
                    i0_d    = hold_i_q;
                    q0_d    = hold_q_q;
                    i1_d    = a_data;
                    q1_d    = b_data;
                end
            end
            default: state_d = SEARCH;
        endcase

        // A runtime mode switch restarts acquisition without counting it as a lock loss.
        if (mode_chg) begin
            state_d = SEARCH;
            phase_d = phase_q;
            lost    = 1'b0;
            valid_d = 1'b0;
            i0_d    = '0;
            q0_d    = '0;
            i1_d    = '0;
            q1_d    = '0;
        end

        err_d = err_clr ? '0 : err_q;
        if (lost && (err_d != '1)) begin
            err_d = err_d + ERR_W'(1);
        end
    end

    always_ff @(posedge rx_data_clk) begin
        if (!rst_n) begin
            state_q  <= SEARCH;
            phase_q  <= 1'b0;
            slot_q   <= 1'b0;
            good_q   <= '0;
            hold_i_q <= '0;
            hold_q_q <= '0;
            err_q    <= '0;
            valid_q  <= 1'b0;
            i0_q     <= '0;
            q0_q     <= '0;
            i1_q     <= '0;
            q1_q     <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            slot_q   <= slot_d;
            good_q   <= good_d;
            hold_i_q <= hold_i_d;
            hold_q_q <= hold_q_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            i0_q     <= i0_d;
            q0_q     <= q0_d;
            i1_q     <= i1_d;
            q1_q     <= q1_d;
        end
    end

    // Tracked through reset as well so a mode held across reset is not seen as a switch.
    always_ff @(posedge rx_data_clk) begin
        mode_q <= mode_2r2t;
    end

    assign adc_valid     = valid_q;
    assign adc_data_i0   = i0_q;
    assign adc_data_q0   = q0_q;
    assign adc_data_i1   = i1_q;
    assign adc_data_q1   = q1_q;
    assign rx_status     = (state_q == LOCKED);
    assign align_phase   = phase_q;
    assign frame_err_cnt = err_q;

endmodule

// File: tb/tb_ad9363_rx_deframer.sv
// Directed bench for ad9363_rx_deframer with a cycle model and literal spot checks.
`timescale 1ns/1ps
module tb_ad9363_rx_deframer;

    localparam int DW    = 12;
    localparam int LOCKN = 4;
    localparam int HUNT  = 0;
    localparam int CHECK = 1;
    localparam int LOCK  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic [DW-1:0] dp = '0, dn = '0;
    logic          fp = 1'b0, fn = 1'b0, mode = 1'b0, clr = 1'b0;

    logic          valid, status, phase;
    logic [DW-1:0] i0, q0, i1, q1;
    logic [15:0]   err;
    logic          sValid, sStatus, sPhase;
    logic [DW-1:0] sI0, sQ0, sI1, sQ1;
    logic [1:0]    sErr;

    int errors = 0;
    int checks = 0;
    bit checkEn = 1'b0;

    ad9363_rx_deframer #(.DATA_W(DW), .LOCK_CNT(LOCKN), .ERR_W(16)) dut (
        .rx_data_clk(clk), .rst_n(rst_n), .ddr_data_p(dp), .ddr_data_n(dn),
        .ddr_frame_p(fp), .ddr_frame_n(fn), .mode_2r2t(mode), .err_clr(clr),
        .adc_valid(valid), .adc_data_i0(i0), .adc_data_q0(q0), .adc_data_i1(i1),
        .adc_data_q1(q1), .rx_status(status), .align_phase(phase), .frame_err_cnt(err)
    );

    ad9363_rx_deframer #(.DATA_W(DW), .LOCK_CNT(LOCKN), .ERR_W(2)) dutSmall (
        .rx_data_clk(clk), .rst_n(rst_n), .ddr_data_p(dp), .ddr_data_n(dn),
        .ddr_frame_p(fp), .ddr_frame_n(fn), .mode_2r2t(mode), .err_clr(clr),
        .adc_valid(sValid), .adc_data_i0(sI0), .adc_data_q0(sQ0), .adc_data_i1(sI1),
        .adc_data_q1(sQ1), .rx_status(sStatus), .align_phase(sPhase), .frame_err_cnt(sErr)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rstI, input logic fpI, input logic fnI,
                                 input logic [DW-1:0] dpI, input logic [DW-1:0] dnI,
                                 input logic modeI, input logic clrI);
        @(negedge clk);
        rst_n = rstI;
        fp    = fpI;
        fn    = fnI;
        dp    = dpI;
        dn    = dnI;
        mode  = modeI;
        clr   = clrI;
    endtask

    // Reference model: what the deframer must present after each clock edge.
    int            mState = HUNT, mGood = 0, mErr = 0, mErrS = 0, fpair = 0, want = 0;
    bit            mPhase = 0, mSlot = 0, mPrevFn = 0, mMode = 0, mValid = 0;
    bit            aF, bF, ok, lost;
    logic [DW-1:0] mHoldA = '0, mHoldB = '0, mPrevN = '0, aD, bD;
    logic [DW-1:0] mI0 = '0, mQ0 = '0, mI1 = '0, mQ1 = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            mState = HUNT; mPhase = 0; mSlot = 0; mGood = 0;
            mHoldA = '0; mHoldB = '0; mPrevN = '0; mPrevFn = 0;
            mValid = 0; mI0 = '0; mQ0 = '0; mI1 = '0; mQ1 = '0;
            mErr = 0; mErrS = 0;
        end else begin
            aD = mPhase ? mPrevN  : dp;
            aF = mPhase ? mPrevFn : fp;
            bD = mPhase ? dp : dn;
            bF = mPhase ? fp : fn;
            fpair = 2 * int'(aF) + int'(bF);
            want  = !mode ? 2 : (mSlot ? 0 : 3);
            ok    = (fpair == want);
            lost  = 0;
            mValid = 0; mI0 = '0; mQ0 = '0; mI1 = '0; mQ1 = '0;
            if (mode != mMode) begin
                mState = HUNT;
            end else if (mState == HUNT) begin
                if (!mode && fp && !fn) begin
                    mPhase = 0; mState = CHECK;
                end else if (mode && fp && fn) begin
                    mPhase = 0; mSlot = 1; mState = CHECK;
                end else if (!fp && fn) begin
                    mPhase = 1; mState = CHECK;
                    if (mode) mSlot = 1;
                end
                mGood = 0;
            end else begin
                if (!mSlot) begin
                    mHoldA = aD; mHoldB = bD;
                end
                if (!ok) begin
                    lost = (mState == LOCK);
                    mState = HUNT;
                end else if (mState == CHECK) begin
                    mGood++;
                    if (mGood == LOCKN) mState = LOCK;
                end else if (!mode) begin
                    mValid = 1; mI0 = aD; mQ0 = bD;
                end else if (mSlot) begin
                    mValid = 1; mI0 = mHoldA; mQ0 = mHoldB; mI1 = aD; mQ1 = bD;
                end
                mSlot = !mSlot;
            end
            if (lost) begin
                mErr  = clr ? 1 : ((mErr == 65535) ? mErr : mErr + 1);
                mErrS = clr ? 1 : ((mErrS == 3) ? mErrS : mErrS + 1);
            end else if (clr) begin
                mErr = 0; mErrS = 0;
            end
            mPrevN  = dn;
            mPrevFn = fn;
        end
        mMode = mode;
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("adc_valid", 32'(valid), 32'(mValid));
            checkOutput("adc_data_i0", 32'(i0), 32'(mI0));
            checkOutput("adc_data_q0", 32'(q0), 32'(mQ0));
            checkOutput("adc_data_i1", 32'(i1), 32'(mI1));
            checkOutput("adc_data_q1", 32'(q1), 32'(mQ1));
            checkOutput("rx_status", 32'(status), 32'(mState == LOCK));
            checkOutput("align_phase", 32'(phase), 32'(mPhase));
            checkOutput("frame_err_cnt", 32'(err), 32'(mErr));
            checkOutput("small valid", 32'(sValid), 32'(mValid));
            checkOutput("small i0", 32'(sI0), 32'(mI0));
            checkOutput("small q0", 32'(sQ0), 32'(mQ0));
            checkOutput("small i1", 32'(sI1), 32'(mI1));
            checkOutput("small q1", 32'(sQ1), 32'(mQ1));
            checkOutput("small status", 32'(sStatus), 32'(mState == LOCK));
            checkOutput("small phase", 32'(sPhase), 32'(mPhase));
            checkOutput("small err_cnt", 32'(sErr), 32'(mErrS));
        end
    end

    initial begin
        $display("[TB] start");
        repeat (3) applyStimulus(0, 0, 0, '0, '0, 0, 0);
        checkEn = 1'b1;
        checkOutput("reset valid", 32'(valid), 0);
        checkOutput("reset status", 32'(status), 0);
        checkOutput("reset err", 32'(err), 0);

        // 1R1T nominal phase.
        for (int j = 1; j <= 12; j++) begin
            applyStimulus(1, 1, 0, 12'h123, 12'h456, 0, 0);
            if (j == 5) checkOutput("t1 status before lock", 32'(status), 0);
            if (j == 6) begin
                checkOutput("t1 status at lock", 32'(status), 1);
                checkOutput("t1 phase", 32'(phase), 0);
            end
            if (j >= 7) begin
                checkOutput("t1 valid", 32'(valid), 1);
                checkOutput("t1 i0", 32'(i0), 32'h123);
                checkOutput("t1 q0", 32'(q0), 32'h456);
                checkOutput("t1 i1", 32'(i1), 0);
            end
        end

        // 1R1T with a half-cycle slip.
        repeat (2) applyStimulus(0, 0, 0, '0, '0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1, 0, 1, DW'(12'h0B0 + k), DW'(12'h0A0 + k), 0, 0);
            if (k == 5) begin
                checkOutput("t2 status", 32'(status), 1);
                checkOutput("t2 phase", 32'(phase), 1);
            end
            if (k >= 6) begin
                checkOutput("t2 i0", 32'(i0), 32'(12'h0A0 + k - 2));
                checkOutput("t2 q0", 32'(q0), 32'(12'h0B0 + k - 1));
            end
        end

        // 2R2T nominal.
        repeat (2) applyStimulus(0, 0, 0, '0, '0, 1, 0);
        for (int j = 0; j < 16; j++) begin
            if (j % 2 == 0) applyStimulus(1, 1, 1, 12'h111, 12'h222, 1, 0);
            else            applyStimulus(1, 0, 0, 12'h333, 12'h444, 1, 0);
            if (j == 5) checkOutput("t3 status", 32'(status), 1);
            if (j >= 6) begin
                checkOutput("t3 valid", 32'(valid), 32'(j % 2 == 0));
                if (j % 2 == 0) begin
                    checkOutput("t3 i0", 32'(i0), 32'h111);
                    checkOutput("t3 q0", 32'(q0), 32'h222);
                    checkOutput("t3 i1", 32'(i1), 32'h333);
                    checkOutput("t3 q1", 32'(q1), 32'h444);
                end
            end
        end

        // Lock losses in 1R1T and counter saturation.
        repeat (2) applyStimulus(0, 0, 0, '0, '0, 0, 0);
        for (int j = 0; j < 8; j++) applyStimulus(1, 1, 0, DW'(12'h200 + j), DW'(12'h300 + j), 0, 0);
        for (int e = 1; e <= 5; e++) begin
            applyStimulus(1, 1, 1, 12'h7FF, 12'h7FF, 0, 0);
            applyStimulus(1, 1, 0, 12'h210, 12'h310, 0, 0);
            checkOutput("t4 status after loss", 32'(status), 0);
            checkOutput("t4 valid after loss", 32'(valid), 0);
            checkOutput("t4 err", 32'(err), 32'(e));
            repeat (7) applyStimulus(1, 1, 0, 12'h220, 12'h320, 0, 0);
            checkOutput("t4 relock", 32'(status), 1);
        end
        checkOutput("t4 err final", 32'(err), 5);
        checkOutput("t4 small err saturated", 32'(sErr), 3);

        // Mode switch while locked, then err_clr coinciding with a lock loss.
        applyStimulus(1, 1, 0, 12'h123, 12'h456, 1, 0);
        applyStimulus(1, 1, 1, 12'h111, 12'h222, 1, 0);
        checkOutput("t5 status after mode switch", 32'(status), 0);
        checkOutput("t5 err unchanged", 32'(err), 5);
        for (int j = 1; j < 12; j++) begin
            if (j % 2 == 0) applyStimulus(1, 1, 1, 12'h111, 12'h222, 1, 0);
            else            applyStimulus(1, 0, 0, 12'h333, 12'h444, 1, 0);
        end
        checkOutput("t5 2r lock", 32'(status), 1);
        applyStimulus(1, 1, 0, 12'h111, 12'h222, 1, 1);
        applyStimulus(1, 0, 0, 12'h333, 12'h444, 1, 0);
        checkOutput("t5 clr+loss err", 32'(err), 1);
        checkOutput("t5 clr+loss small err", 32'(sErr), 1);
        for (int j = 0; j < 10; j++) begin
            if (j % 2 == 0) applyStimulus(1, 1, 1, 12'h111, 12'h222, 1, 0);
            else            applyStimulus(1, 0, 0, 12'h333, 12'h444, 1, 0);
        end
        applyStimulus(1, 1, 1, 12'h111, 12'h222, 1, 1);
        applyStimulus(1, 0, 0, 12'h333, 12'h444, 1, 0);
        checkOutput("t5 clr alone", 32'(err), 0);
        checkOutput("t5 still locked", 32'(status), 1);

        // Reset in the middle of a 2R2T frame.
        applyStimulus(0, 1, 1, 12'h5A5, 12'h0F0, 1, 0);
        applyStimulus(1, 0, 0, 12'h3C3, 12'h777, 1, 0);
        checkOutput("t6 valid", 32'(valid), 0);
        checkOutput("t6 status", 32'(status), 0);
        checkOutput("t6 i1", 32'(i1), 0);
        checkOutput("t6 err", 32'(err), 0);
        for (int j = 0; j < 12; j++) begin
            if (j % 2 == 0) applyStimulus(1, 1, 1, 12'h5A5, 12'h0F0, 1, 0);
            else            applyStimulus(1, 0, 0, 12'h3C3, 12'h777, 1, 0);
        end
        applyStimulus(1, 1, 1, 12'h5A5, 12'h0F0, 1, 0);
        checkOutput("t6 relock", 32'(status), 1);
        checkOutput("t6 valid after relock", 32'(valid), 1);
        checkOutput("t6 i0", 32'(i0), 32'h5A5);
        checkOutput("t6 q1", 32'(q1), 32'h777);

        @(negedge clk);
        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
